// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN classification collector.
package cnn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 113;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 16;

    // Collector control states: waiting for a frame, ranking scores, presenting a record.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Most-negative score; seeds the runner-up so any real score displaces it.
    localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

endpackage

// File: rtl/score_rank_update.sv
// Combinational best/runner-up update for one candidate score.
// Strict compares keep the lower index on ties for both places.
module score_rank_update #(
    parameter int SCORE_W = cnn_pkg::SCORE_W,
    parameter int IDX_W   = cnn_pkg::IDX_W
) (
    input  logic signed [SCORE_W-1:0] best_score,
    input  logic        [IDX_W-1:0]   best_idx,
    input  logic signed [SCORE_W-1:0] second_score,
    input  logic        [IDX_W-1:0]   second_idx,
    input  logic signed [SCORE_W-1:0] cand_score,
    input  logic        [IDX_W-1:0]   cand_idx,
    output logic signed [SCORE_W-1:0] new_best_score,
    output logic        [IDX_W-1:0]   new_best_idx,
    output logic signed [SCORE_W-1:0] new_second_score,
    output logic        [IDX_W-1:0]   new_second_idx
);

    // Candidate either takes the lead (old leader drops to second) or only beats the runner-up.
    always_comb begin
        new_best_score   = best_score;
        new_best_idx     = best_idx;
        new_second_score = second_score;
        new_second_idx   = second_idx;
        if (cand_score > best_score) begin
            new_second_score = best_score;
            new_second_idx   = best_idx;
            new_best_score   = cand_score;
            new_best_idx     = cand_idx;
        end else if (cand_score > second_score) begin
            new_second_score = cand_score;
            new_second_idx   = cand_idx;
        end
    end

endmodule

// File: rtl/cnn_class_collector.sv
// Captures the FC-stage class scores on each fc_done rising edge, re-ranks them
// serially, cross-checks the CNN's argmax and hands out one record per image.
module cnn_class_collector #(
    parameter int SCORE_W     = cnn_pkg::SCORE_W,
    parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
    parameter int IDX_W       = cnn_pkg::IDX_W,
    parameter int CNT_W       = cnn_pkg::CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fc_done,
    input  logic        [IDX_W-1:0]   cnn_result,
    input  logic signed [SCORE_W-1:0] prob_0,
    input  logic signed [SCORE_W-1:0] prob_1,
    input  logic signed [SCORE_W-1:0] prob_2,
    input  logic signed [SCORE_W-1:0] prob_3,
    input  logic signed [SCORE_W-1:0] prob_4,
    input  logic signed [SCORE_W-1:0] prob_5,
    input  logic signed [SCORE_W-1:0] prob_6,
    input  logic signed [SCORE_W-1:0] prob_7,
    input  logic signed [SCORE_W-1:0] prob_8,
    input  logic signed [SCORE_W-1:0] prob_9,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [IDX_W-1:0]   class_idx,
    output logic        [IDX_W-1:0]   runner_idx,
    output logic signed [SCORE_W-1:0] best_score,
    output logic        [SCORE_W:0]   margin,
    output logic                      mismatch,
    output logic                      busy,
    output logic        [CNT_W-1:0]   img_count,
    output logic        [CNT_W-1:0]   err_count,
    output logic        [CNT_W-1:0]   drop_count
);

    import cnn_pkg::state_t;
    import cnn_pkg::IDLE;
    import cnn_pkg::SCAN;
    import cnn_pkg::HOLD;

    localparam int NUM_INPUTS = 10;
    localparam logic signed [SCORE_W-1:0] SCORE_MIN  = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic        [IDX_W:0]     SCAN_FIRST = (IDX_W+1)'(1);
    // One extra SCAN cycle after the last class registers the record from settled best/second.
    localparam logic        [IDX_W:0]     SCAN_END   = (IDX_W+1)'(NUM_CLASSES);

    state_t state, state_next;

    logic                      fc_done_q;
    logic                      start;
    logic signed [SCORE_W-1:0] probs   [NUM_INPUTS];
    logic signed [SCORE_W-1:0] score_r [NUM_INPUTS];
    logic        [IDX_W-1:0]   cnn_q;
    logic        [IDX_W:0]     scan_idx;
    logic signed [SCORE_W-1:0] best_s, second_s;
    logic        [IDX_W-1:0]   best_i, second_i;
    logic signed [SCORE_W-1:0] upd_best_s, upd_second_s;
    logic        [IDX_W-1:0]   upd_best_i, upd_second_i;
    logic signed [SCORE_W:0]   diff;

    assign probs[0] = prob_0;
    assign probs[1] = prob_1;
    assign probs[2] = prob_2;
    assign probs[3] = prob_3;
    assign probs[4] = prob_4;
    assign probs[5] = prob_5;
    assign probs[6] = prob_6;
    assign probs[7] = prob_7;
    assign probs[8] = prob_8;
    assign probs[9] = prob_9;

    assign start = fc_done & ~fc_done_q;

    // Sign-extended difference; best never ranks below second, so this is non-negative.
    assign diff = {best_s[SCORE_W-1], best_s} - {second_s[SCORE_W-1], second_s};

    score_rank_update #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_rank (
        .best_score       (best_s),
        .best_idx         (best_i),
        .second_score     (second_s),
        .second_idx       (second_i),
        .cand_score       (score_r[scan_idx[IDX_W-1:0]]),
        .cand_idx         (scan_idx[IDX_W-1:0]),
        .new_best_score   (upd_best_s),
        .new_best_idx     (upd_best_i),
        .new_second_score (upd_second_s),
        .new_second_idx   (upd_second_i)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state decode and busy flag.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        unique case (state)
            IDLE: if (start) state_next = SCAN;
            SCAN: begin
                busy = 1'b1;
                if (scan_idx == SCAN_END) state_next = HOLD;
            end
            HOLD: begin
                busy = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture, serial ranking, record presentation and statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fc_done_q  <= 1'b0;
            for (int k = 0; k < NUM_INPUTS; k++) score_r[k] <= '0;
            cnn_q      <= '0;
            scan_idx   <= '0;
            best_s     <= '0;
            best_i     <= '0;
            second_s   <= '0;
            second_i   <= '0;
            out_valid  <= 1'b0;
            class_idx  <= '0;
            runner_idx <= '0;
            best_score <= '0;
            margin     <= '0;
            mismatch   <= 1'b0;
            img_count  <= '0;
            err_count  <= '0;
            drop_count <= '0;
        end else begin
            fc_done_q <= fc_done;
            if (start && state != IDLE) drop_count <= drop_count + CNT_W'(1);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NUM_INPUTS; k++) score_r[k] <= probs[k];
                        cnn_q    <= cnn_result;
                        best_s   <= probs[0];
                        best_i   <= '0;
                        second_s <= SCORE_MIN;
                        second_i <= '0;
                        scan_idx <= SCAN_FIRST;
                    end
                end
                SCAN: begin
                    if (scan_idx != SCAN_END) begin
                        best_s   <= upd_best_s;
                        best_i   <= upd_best_i;
                        second_s <= upd_second_s;
                        second_i <= upd_second_i;
                        scan_idx <= scan_idx + (IDX_W+1)'(1);
                    end else begin
                        class_idx  <= best_i;
                        runner_idx <= second_i;
                        best_score <= best_s;
                        margin     <= $unsigned(diff);
                        mismatch   <= (best_i != cnn_q);
                        out_valid  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        img_count <= img_count + CNT_W'(1);
                        if (mismatch) err_count <= err_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_class_collector.sv
// Scoreboard bench for cnn_class_collector: stimulus pushes expected records,
// a negedge monitor compares every presented record against the queue head.
module tb_cnn_class_collector;

    localparam int SW = 113;
    localparam int IW = 4;

    typedef struct {
        logic        [IW-1:0] cls;
        logic        [IW-1:0] run;
        logic signed [SW-1:0] best;
        logic        [SW:0]   marg;
        logic                 mm;
    } rec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 fc_done = 1'b0;
    logic        [IW-1:0] cnn_result = '0;
    logic signed [SW-1:0] p [10];
    logic                 out_ready = 1'b0;

    logic                 out_valid, mismatch, busy;
    logic        [IW-1:0] class_idx, runner_idx;
    logic signed [SW-1:0] best_score;
    logic        [SW:0]   margin;
    logic        [15:0]   img_count, err_count, drop_count;

    logic                 w_out_valid, w_mismatch, w_busy;
    logic        [IW-1:0] w_class_idx, w_runner_idx;
    logic signed [SW-1:0] w_best_score;
    logic        [SW:0]   w_margin;
    logic        [3:0]    w_img_count, w_err_count, w_drop_count;

    int   checks = 0;
    int   failures = 0;
    rec_t exp_q [$];
    int   exp_img = 0, exp_err = 0, exp_drop = 0;

    always #5 clk = ~clk;

    cnn_class_collector dut (
        .clk(clk), .rst(rst), .fc_done(fc_done), .cnn_result(cnn_result),
        .prob_0(p[0]), .prob_1(p[1]), .prob_2(p[2]), .prob_3(p[3]), .prob_4(p[4]),
        .prob_5(p[5]), .prob_6(p[6]), .prob_7(p[7]), .prob_8(p[8]), .prob_9(p[9]),
        .out_valid(out_valid), .out_ready(out_ready), .class_idx(class_idx),
        .runner_idx(runner_idx), .best_score(best_score), .margin(margin),
        .mismatch(mismatch), .busy(busy), .img_count(img_count),
        .err_count(err_count), .drop_count(drop_count)
    );

    // Narrow-counter copy on the same inputs, used to exercise counter wrap quickly.
    cnn_class_collector #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .fc_done(fc_done), .cnn_result(cnn_result),
        .prob_0(p[0]), .prob_1(p[1]), .prob_2(p[2]), .prob_3(p[3]), .prob_4(p[4]),
        .prob_5(p[5]), .prob_6(p[6]), .prob_7(p[7]), .prob_8(p[8]), .prob_9(p[9]),
        .out_valid(w_out_valid), .out_ready(out_ready), .class_idx(w_class_idx),
        .runner_idx(w_runner_idx), .best_score(w_best_score), .margin(w_margin),
        .mismatch(w_mismatch), .busy(w_busy), .img_count(w_img_count),
        .err_count(w_err_count), .drop_count(w_drop_count)
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic rec_t mk(input int c, input int r, input int b, input int m, input bit mm);
        rec_t e;
        e.cls  = IW'(c);
        e.run  = IW'(r);
        e.best = SW'(b);
        e.marg = (SW+1)'(m);
        e.mm   = mm;
        return e;
    endfunction

    // Monitor: every cycle a record is presented it must match the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL record_unexpected actual=valid required=no_record cls=%0d", class_idx);
            end else begin
                if (class_idx !== exp_q[0].cls || runner_idx !== exp_q[0].run ||
                    best_score !== exp_q[0].best || margin !== exp_q[0].marg ||
                    mismatch !== exp_q[0].mm) begin
                    failures++;
                    $display("FAIL record actual cls=%0d run=%0d best=%0d margin=%0d mm=%0d required cls=%0d run=%0d best=%0d margin=%0d mm=%0d",
                             class_idx, runner_idx, best_score, margin, mismatch,
                             exp_q[0].cls, exp_q[0].run, exp_q[0].best, exp_q[0].marg, exp_q[0].mm);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Pulse fc_done for one cycle; on return the capture edge has just passed.
    task automatic pulse(input logic [IW-1:0] cnn);
        @(posedge clk); #1;
        cnn_result = cnn;
        fc_done    = 1'b1;
        @(posedge clk); #1;
        fc_done    = 1'b0;
    endtask

    // Count edges after the capture edge until out_valid shows; bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_valid_timeout actual=%0d required=10", n);
        end
    endtask

    task automatic accept(input bit mm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_img++;
        if (mm) exp_err++;
    endtask

    task automatic load_t1();
        p[0] = 10;  p[1] = 20; p[2] = 300; p[3] = -50; p[4] = 100;
        p[5] = 0;   p[6] = 7;  p[7] = 500; p[8] = 99;  p[9] = -1;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_img"},  img_count,  exp_img);
        chk({tag, "_err"},  err_count,  exp_err);
        chk({tag, "_drop"}, drop_count, exp_drop);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 10; k++) p[k] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_class", class_idx, 0);
        chk("rst_margin_zero", (margin == 0), 1);
        chk_counts("rst");
        rst = 1'b1;

        // T1: distinct scores, max at class 7, runner at class 2
        load_t1();
        exp_q.push_back(mk(7, 2, 500, 200, 0));
        pulse(4'd7);
        wait_valid(n);
        chk("t1_latency", n, 10);
        chk("t1_busy", busy, 1);
        accept(0);
        chk_counts("t1");
        chk("t1_valid_drop", out_valid, 0);

        // T2: ties and negatives, lower index wins, CNN disagrees
        for (int k = 0; k < 10; k++) p[k] = -5;
        p[3] = 40; p[8] = 40;
        exp_q.push_back(mk(3, 8, 40, 0, 1));
        pulse(4'd8);
        wait_valid(n);
        chk("t2_latency", n, 10);
        accept(1);
        chk_counts("t2");

        // T3: backpressure for 20 cycles with a second fc_done edge at cycle 15
        for (int k = 0; k < 10; k++) p[k] = 0;
        p[1] = 600; p[5] = 1000;
        exp_q.push_back(mk(5, 1, 1000, 400, 0));
        pulse(4'd5);
        wait_valid(n);
        chk("t3_latency", n, 10);
        for (int cyc = 10; cyc < 30; cyc++) begin
            if (cyc == 14) fc_done = 1'b1;
            if (cyc == 15) fc_done = 1'b0;
            @(posedge clk); #1;
        end
        exp_drop++;
        chk("t3_still_valid", out_valid, 1);
        chk("t3_busy_hold", busy, 1);
        chk_counts("t3_hold");
        accept(0);
        chk_counts("t3");

        // T4: fc_done held high 50 cycles gives exactly one record
        for (int k = 0; k < 9; k++) p[k] = k;
        p[9] = 77;
        exp_q.push_back(mk(9, 8, 77, 69, 0));
        @(posedge clk); #1;
        cnn_result = 4'd9;
        fc_done    = 1'b1;
        out_ready  = 1'b1;
        repeat (50) begin @(posedge clk); #1; end
        fc_done = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        exp_img++;
        chk_counts("t4");
        chk("t4_queue_empty", exp_q.size(), 0);

        // T5: reset during scan aborts the record and clears counters
        load_t1();
        pulse(4'd7);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        exp_img = 0; exp_err = 0; exp_drop = 0;
        chk("t5_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk_counts("t5");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        chk("t5_no_valid", out_valid, 0);
        exp_q.push_back(mk(7, 2, 500, 200, 0));
        pulse(4'd7);
        wait_valid(n);
        chk("t5_latency", n, 10);
        accept(0);
        chk_counts("t5_after");

        // T6: counter wrap on the 4-bit copy; every third image carries a wrong CNN label
        for (int k = 0; k < 10; k++) p[k] = 3 * k;
        for (int k = 0; k < 15; k++) begin
            bit mm;
            mm = (k % 3 == 0);
            exp_q.push_back(mk(9, 8, 27, 3, mm));
            pulse(mm ? 4'd2 : 4'd9);
            wait_valid(n);
            accept(mm);
            if (k == 13) chk("t6_w_img_15", w_img_count, 15);
        end
        chk_counts("t6");
        chk("t6_w_img_wrap", w_img_count, exp_img % 16);
        chk("t6_w_img_zero", w_img_count, 0);
        chk("t6_w_err", w_err_count, exp_err % 16);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnn_class_collector.md
Name: cnn_class_collector

Overview:
- Downstream consumer of the simpleCNN fully-connected stage.
- On each fc_done rising edge it captures the ten signed class scores and re-derives the argmax with a serial one-class-per-cycle scan. It also computes the runner-up class and the decision margin.
- It cross-checks its argmax against the CNN's own result and presents one classification record per image over a valid/ready handshake.
- It keeps wrap-around counters of classified images, mismatches and dropped frames.

Parameters:
- SCORE_W, 113, width of each signed class score.
- NUM_CLASSES, 10, number of classes scanned (2..16).
- IDX_W, 4, class index width.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-low.
- fc_done  in  1  CNN FC-complete flag; level may persist across cycles.
- cnn_result  in  IDX_W  CNN's argmax, sampled with scores.
- prob_0 .. prob_9  in  SCORE_W each  signed class scores.
- out_valid  out  1  classification record available.
- out_ready  in  1  consumer accepts the record.
- class_idx  out  IDX_W  argmax class.
- runner_idx  out  IDX_W  second-best class.
- best_score  out  SCORE_W  signed winning score.
- margin  out  SCORE_W+1  unsigned best_score minus second-best score.
- mismatch  out  1  class_idx differs from captured cnn_result; valid with out_valid.
- busy  out  1  high in SCAN or HOLD.
- img_count  out  CNT_W  records accepted (handshakes completed).
- err_count  out  CNT_W  accepted records with mismatch=1.
- drop_count  out  CNT_W  fc_done edges ignored while busy.

Behaviour:
- Reset (rst=0, async): all outputs, counters and score registers are 0, state is IDLE, and the fc_done edge-detect register is 0.
- Edge detect: start = fc_done & ~fc_done_q. fc_done_q is registered every cycle in all states.
- IDLE: on start, capture prob_0..9 and cnn_result into internal registers. Initialise best=score0 (idx 0) and second=most-negative value (idx 0). Set scan index=1 and go to SCAN.
- SCAN: one class per cycle, i = 1..NUM_CLASSES-1.
  - If score_i > best: second<=best, runner<=best idx, best<=score_i, best idx<=i.
  - Else if score_i > second: second<=score_i, runner<=i.
  - Ties: the strictly greater compare means the lower index wins for both best and second.
- After i = NUM_CLASSES-1 is evaluated, register the outputs and go to HOLD with out_valid=1.
  - margin = best - second, computed in SCORE_W+1 signed and always non-negative.
  - mismatch = (best idx != captured cnn_result).
- Latency: start at cycle 0 (capture edge) gives out_valid=1 at cycle NUM_CLASSES (cycle 10 with defaults).
- HOLD: outputs remain stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: img_count++, and err_count++ if mismatch.
  - out_valid drops next cycle and state returns to IDLE.
  - A start in the same cycle as the handshake is counted as dropped; there is no back-to-back capture.
- Drop: start while busy (SCAN or HOLD) increments drop_count. Captured scores are untouched.
- out_ready is ignored outside HOLD.
- All counters wrap modulo 2^CNT_W with no saturation.
- Reset mid-SCAN or mid-HOLD aborts immediately. The record is lost, counters clear and out_valid is 0.
- fc_done held high for many cycles produces exactly one capture.

Decomposition:
- Shared package cnn_pkg:
  - constants NUM_CLASSES, SCORE_W, IDX_W, CNT_W;
  - the state enum IDLE/SCAN/HOLD;
  - SCORE_MIN, the most-negative SCORE_W constant.
- One sub-module, score_rank_update, combinational. It takes the current best/second (score, idx) and a candidate (score, idx) and returns the updated pair. This isolates the wide compares for reuse and timing work.

Test Plan:
- Distinct scores with prob_7=500 the maximum, prob_2=300 second, others ≤100, cnn_result=7, pulse fc_done.
  - Required: out_valid at cycle 10, class_idx=7, runner_idx=2, best_score=500, margin=200, mismatch=0.
  - After out_ready=1: img_count=1, err_count=0.
- Tie and negative values: all scores -5 except prob_3=prob_8=40, cnn_result=8.
  - Required: class_idx=3, runner_idx=8, margin=0, mismatch=1.
  - On accept: err_count=1.
- Backpressure: out_ready=0 for 20 cycles after out_valid, with a second fc_done edge at cycle 15.
  - Required: outputs stable, drop_count=1.
  - After out_ready=1: img_count increments by exactly 1.
- fc_done held high 50 cycles.
  - Required: exactly one record, drop_count unchanged.
- Reset asserted at scan cycle 5.
  - Required: out_valid never rises, all counters 0.
  - The next fc_done produces a normal record.
- Wrap: 65536 accepted images.
  - Required: img_count returns to 0 and err_count is consistent with the injected mismatches.
